// File: rtl/posit_pack_round.sv
// Posit pack-and-round output stage: builds regime|exponent|fraction, rounds to nearest-even
// with maxpos/minpos saturation, then applies the sign in a second registered stage.
module posit_pack_round #(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int RS = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          Sign,
    input  logic          Zero,
    input  logic          NaR,
    input  logic [RS:0]   R_O,
    input  logic [ES-1:0] E_O,
    input  logic [N-1:0]  Frac,
    input  logic          Sticky,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  Result
);
    localparam int W = 2 * N + ES;
    localparam logic [N-2:0] MAXPOS_BODY = {(N - 1){1'b1}};
    localparam logic [N-2:0] MINPOS_BODY = {{(N - 2){1'b0}}, 1'b1};

    logic          s1_valid_q, s1_valid_d;
    logic [N-2:0]  s1_body_q, s1_body_d;
    logic          s1_sign_q, s1_sign_d;
    logic          s1_zero_q, s1_zero_d;
    logic          s1_nar_q, s1_nar_d;
    logic          s2_valid_q, s2_valid_d;
    logic [N-1:0]  result_q, result_d;

    logic          s2_advance_s;
    logic          s1_load_s;
    int            k_s;
    int            reg_len_s;
    logic [W-1:0]  reg_pat_s;
    logic [W-1:0]  ext_s;
    logic [N-2:0]  body_s;
    logic [N-2:0]  body_rnd_s;
    logic          guard_s;
    logic          sticky_s;

    // Handshake: a stage may take new data when it is empty or its contents move on.
    always_comb begin
        s2_advance_s = !s2_valid_q || out_ready;
        in_ready     = !s1_valid_q || s2_advance_s;
        s1_load_s    = in_valid && in_ready;
        out_valid    = s2_valid_q;
        Result       = result_q;
    end

    // Stage 1: assemble the unsigned body and round it to nearest-even.
    always_comb begin
        k_s = {{(32 - RS - 1){R_O[RS]}}, R_O};
        if (k_s >= 0) begin
            reg_len_s = k_s + 2;
            reg_pat_s = ~({W{1'b1}} >> (k_s + 1));
        end else begin
            reg_len_s = 1 - k_s;
            reg_pat_s = {1'b1, {(W - 1){1'b0}}} >> (-k_s);
        end
        ext_s    = reg_pat_s | ({E_O, Frac, {N{1'b0}}} >> reg_len_s);
        body_s   = ext_s[W-1 -: N-1];
        guard_s  = ext_s[W-N];
        sticky_s = (|ext_s[W-N-1:0]) | Sticky;

        // An all-ones body cannot be incremented; it is already maxpos.
        if (guard_s && (sticky_s || body_s[0]) && !(&body_s)) begin
            body_rnd_s = body_s + MINPOS_BODY;
        end else begin
            body_rnd_s = body_s;
        end

        if (Zero) begin
            s1_body_d = {(N - 1){1'b0}};
        end else if (k_s >= N - 2) begin
            s1_body_d = MAXPOS_BODY;
        end else if (k_s <= -(N - 1)) begin
            s1_body_d = MINPOS_BODY;
        end else if (body_rnd_s == {(N - 1){1'b0}}) begin
            s1_body_d = MINPOS_BODY;
        end else begin
            s1_body_d = body_rnd_s;
        end

        s1_sign_d = Sign;
        s1_zero_d = Zero;
        s1_nar_d  = NaR;
        if (!s1_load_s) begin
            s1_body_d = s1_body_q;
            s1_sign_d = s1_sign_q;
            s1_zero_d = s1_zero_q;
            s1_nar_d  = s1_nar_q;
        end else begin
            s1_sign_d = Sign;
        end

        if (in_ready) begin
            s1_valid_d = in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2: apply special values and the sign, holding the result while stalled.
    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        if (s2_advance_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (s1_nar_q) begin
                    result_d = {1'b1, {(N - 1){1'b0}}};
                end else if (s1_zero_q) begin
                    result_d = {N{1'b0}};
                end else if (s1_sign_q) begin
                    result_d = {N{1'b0}} - {1'b0, s1_body_q};
                end else begin
                    result_d = {1'b0, s1_body_q};
                end
            end else begin
                result_d = result_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_body_q  <= {(N - 1){1'b0}};
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= {N{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_body_q  <= s1_body_d;
            s1_sign_q  <= s1_sign_d;
            s1_zero_q  <= s1_zero_d;
            s1_nar_q   <= s1_nar_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
        end
    end
endmodule

// File: tb/tb_posit_pack_round.sv
// Self-checking bench for posit_pack_round: directed vectors pinned to hand values, an
// arithmetic reference model, and a scoreboard/compare process checking every cycle.
module tb_posit_pack_round;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       Sign, Zero, NaR, Sticky;
    logic [3:0] R_O;
    logic [2:0] E_O;
    logic [7:0] Frac;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Result;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [7:0] sb[$];
    int         acq[$];
    logic       tog_en = 1'b0;
    logic [3:0] pat = 4'b1001;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_res = 8'h00;

    posit_pack_round #(.N(8), .ES(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Sign(Sign), .Zero(Zero), .NaR(NaR), .R_O(R_O), .E_O(E_O), .Frac(Frac),
        .Sticky(Sticky), .out_valid(out_valid), .out_ready(out_ready), .Result(Result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: build the bit string arithmetically, round on the integer remainder.
    function automatic logic [7:0] model(input logic s, input logic z, input logic n,
                                         input int k, input int e, input int f, input logic st);
        longint bits, rem, rem2, half2;
        int len, sh, body;
        if (n) return 8'h80;
        if (z) return 8'h00;
        if (k >= 6) body = 127;
        else if (k <= -7) body = 1;
        else begin
            if (k >= 0) begin
                bits = ((64'd1 << (k + 1)) - 1) << 1;
                len  = k + 2;
            end else begin
                bits = 1;
                len  = 1 - k;
            end
            bits = (bits << 3) + e;
            bits = (bits << 8) + f;
            len  = len + 11;
            sh   = len - 7;
            body = int'(bits >> sh);
            rem  = bits % (64'd1 << sh);
            rem2 = rem * 2 + (st ? 1 : 0);
            half2 = 64'd1 << sh;
            if ((rem2 > half2 || (rem2 == half2 && body % 2 == 1)) && body != 127) body = body + 1;
            if (body == 0) body = 1;
        end
        if (s) return 8'((256 - body) % 256);
        return 8'(body);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (tog_en) out_ready = pat[cyc % 4];
    endtask

    task automatic send(input logic s, input logic z, input logic n, input int k,
                        input int e, input int f, input logic st);
        logic acc;
        acc = 1'b0;
        Sign = s; Zero = z; NaR = n; R_O = 4'(k); E_O = 3'(e); Frac = 8'(f); Sticky = st;
        in_valid = 1'b1;
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) begin
                sb.push_back(model(s, z, n, k, e, f, st));
                acq.push_back(cyc);
            end
        end
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: in_ready stuck low, expected acceptance within 40 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic pin(input string name, input logic s, input logic z, input logic n, input int k,
                       input int e, input int f, input logic st, input logic [7:0] exp);
        check({"model_", name}, model(s, z, n, k, e, f, st), exp);
        send(s, z, n, k, e, f, st);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb.size() > 0; t++) step();
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d items left, expected 0", sb.size());
        end
    endtask

    // Scoreboard compare: occupancy, latency, stall stability and ordered results.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("out_valid", 8'(out_valid), 8'((sb.size() > 0 && cyc - acq[0] >= 1) ? 1 : 0));
            check("in_ready", 8'(in_ready), 8'((sb.size() == 2 && !out_ready) ? 0 : 1));
            if (prev_stall) check("stall_stable", Result, prev_res);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL stale_output: got %h with no item in flight", Result);
                end else begin
                    check("result", Result, sb[0]);
                    void'(sb.pop_front());
                    void'(acq.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = Result;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Sign = 1'b0; Zero = 1'b0; NaR = 1'b0; R_O = 4'd0; E_O = 3'd0; Frac = 8'd0; Sticky = 1'b0;
        step(); step();
        rst_n = 1'b1;
        check("reset_out_valid", 8'(out_valid), 8'h00);
        check("reset_result", Result, 8'h00);
        check("reset_in_ready", 8'(in_ready), 8'h01);

        pin("one",        0, 0, 0,  0, 0, 8'h00, 0, 8'h40);
        drain();
        pin("e5",         0, 0, 0,  0, 5, 8'hC0, 0, 8'h57);
        pin("tie_odd",    0, 0, 0,  0, 0, 8'h60, 0, 8'h42);
        pin("tie_even",   0, 0, 0,  0, 0, 8'h20, 0, 8'h40);
        pin("tie_sticky", 0, 0, 0,  0, 0, 8'h20, 1, 8'h41);
        pin("neg_one",    1, 0, 0,  0, 0, 8'h00, 0, 8'hC0);
        pin("k7",         0, 0, 0,  7, 0, 8'h00, 0, 8'h7F);
        pin("k6",         0, 0, 0,  6, 2, 8'h10, 0, 8'h7F);
        pin("k5_ovf",     0, 0, 0,  5, 7, 8'h00, 0, 8'h7F);
        pin("k5",         0, 0, 0,  5, 0, 8'h00, 0, 8'h7E);
        pin("km8",        0, 0, 0, -8, 0, 8'h00, 0, 8'h01);
        pin("km8_neg",    1, 0, 0, -8, 0, 8'h00, 0, 8'hFF);
        pin("km7",        0, 0, 0, -7, 7, 8'hFF, 1, 8'h01);
        pin("km6_rnd",    0, 0, 0, -6, 4, 8'h00, 0, 8'h02);
        pin("km1",        0, 0, 0, -1, 3, 8'h80, 0, 8'h2E);
        pin("km1_neg",    1, 0, 0, -1, 3, 8'h80, 0, 8'hD2);
        pin("nar",        0, 1, 1,  0, 0, 8'h00, 0, 8'h80);
        pin("zero",       1, 1, 0,  3, 5, 8'hAA, 1, 8'h00);
        drain();

        tog_en = 1'b1;
        for (int i = 0; i < 10; i++)
            send(1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom_range(0, 15) - 8,
                 $urandom_range(0, 7), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
        drain();
        tog_en = 1'b0;

        out_ready = 1'b0;
        send(0, 0, 0, 1, 2, 8'h33, 0);
        send(1, 0, 0, 2, 1, 8'h44, 0);
        rst_n = 1'b0;
        step();
        check("rst_mid_out_valid", 8'(out_valid), 8'h00);
        check("rst_mid_result", Result, 8'h00);
        sb.delete();
        acq.delete();
        rst_n = 1'b1;
        check("rst_mid_in_ready", 8'(in_ready), 8'h01);
        out_ready = 1'b1;
        repeat (6) step();
        pin("after_rst",  0, 0, 0,  0, 0, 8'h00, 0, 8'h40);
        drain();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
